// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU issue controller slice.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned ALU_TAG_W  = 4;
    localparam int unsigned OPS_W      = 16;

    // Issue FSM: idle, waiting out the ALU latency, capturing the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_e;

    // One response FIFO entry at default widths
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  cout;
        logic                  sel;
        logic [ALU_TAG_W-1:0]  tag;
    } rsp_entry_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response handshakes between the sequencer and the issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
    parameter int unsigned TAG_W  = alu_pkg::ALU_TAG_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_sel;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;
    logic              rsp_sel;
    logic [TAG_W-1:0]  rsp_tag;

    // Sequencer / response consumer side
    modport master (
        output req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_sel, rsp_tag
    );

    // Issue controller side
    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_sel, rsp_tag
    );
endinterface

// File: rtl/alu_rsp_fifo.sv
// Small response FIFO with a registered head that holds the last popped entry when empty.
module alu_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 38
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointer/count update and selection of the head entry visible after this edge
    always_comb begin
        pop_ok   = pop_i & valid_q;
        push_ok  = push_i & ((cnt_q < CNT_W'(DEPTH)) | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        valid_d  = (cnt_d != '0);
        rdata_d  = rdata_q;
        if (cnt_d != '0) begin
            // A push landing exactly at the new head bypasses the array
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to the registered ALU, waits its latency and queues the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W    = ALU_DATA_W,
    parameter int unsigned TAG_W     = ALU_TAG_W,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_ctrl_if.slave    bus,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_sel,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_cout,
    output logic [OPS_W-1:0]   ops_done
);

    localparam int unsigned LAT_W   = 3;
    localparam int unsigned ENTRY_W = DATA_W + 2 + TAG_W;
    localparam int unsigned CNT_W   = $clog2(RSP_DEPTH + 1);

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sel_q, sel_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [OPS_W-1:0]    ops_q, ops_d;
    logic                ready_q, ready_d;
    logic                fire_c;
    logic                push_c;
    logic                pop_c;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [ENTRY_W-1:0]  fifo_wdata;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_valid;

    // Next-state, operand load and capture control
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        tag_d   = tag_q;
        ops_d   = ops_q;
        push_c  = 1'b0;
        fire_c  = bus.req_valid & ready_q;
        pop_c   = fifo_valid & bus.rsp_ready;

        unique case (state_q)
            IDLE: begin
                if (fire_c) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    sel_d   = bus.req_sel;
                    tag_d   = bus.req_tag;
                    lat_d   = LAT_W'(ALU_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                push_c = 1'b1;
                if (ops_q != {OPS_W{1'b1}}) begin
                    ops_d = ops_q + OPS_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Space check uses the post-edge occupancy, so a pop shows up one cycle later
        cnt_next = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
        ready_d  = (state_d == IDLE) && (cnt_next < CNT_W'(RSP_DEPTH));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            tag_q   <= '0;
            ops_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            tag_q   <= tag_d;
            ops_q   <= ops_d;
            ready_q <= ready_d;
        end
    end

    assign fifo_wdata = {alu_result, alu_cout, sel_q, tag_q};

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (fifo_wdata),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = fifo_valid;
    assign {bus.rsp_result, bus.rsp_cout, bus.rsp_sel, bus.rsp_tag} = fifo_rdata;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sel  = sel_q;
    assign ops_done = ops_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench: directed requests push expectations, monitors pop and compare responses.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct {
        rsp_entry_t e;
        int         fire;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   bg_done = 1'b0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t x1, x3;

    logic [31:0] a1, b1, res1, a3, b3, res3;
    logic        sel1, cout1, sel3, cout3;
    logic [15:0] ops1, ops3;
    logic [32:0] p1;
    logic [32:0] p3 [3];

    alu_issue_ctrl_if #(.DATA_W(32), .TAG_W(4)) if1 ();
    alu_issue_ctrl_if #(.DATA_W(32), .TAG_W(4)) if3 ();

    alu_issue_ctrl #(.DATA_W(32), .TAG_W(4), .ALU_LAT(1), .RSP_DEPTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .alu_a(a1), .alu_b(b1), .alu_sel(sel1),
        .alu_result(res1), .alu_cout(cout1), .ops_done(ops1)
    );

    alu_issue_ctrl #(.DATA_W(32), .TAG_W(4), .ALU_LAT(3), .RSP_DEPTH(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3),
        .alu_a(a3), .alu_b(b3), .alu_sel(sel3),
        .alu_result(res3), .alu_cout(cout3), .ops_done(ops3)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Stub ALUs: sel=0 adds with carry, sel=1 returns ~B with no carry
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic s);
        return s ? {1'b0, ~b} : ({1'b0, a} + {1'b0, b});
    endfunction

    always_ff @(posedge clk) begin
        p1    <= alu_f(a1, b1, sel1);
        p3[0] <= alu_f(a3, b3, sel3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {cout1, res1} = p1;
    assign {cout3, res3} = p3[2];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic rdy(input int d);
        return (d == 1) ? if1.req_ready : if3.req_ready;
    endfunction

    // Drive one request, wait (bounded) for acceptance, record the expectation at fire
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic sel,
                        input logic [3:0] tag, input logic [31:0] er, input logic ec,
                        input bit push, input bit lat);
        exp_t x;
        int   n;
        @(posedge clk);
        #1;
        if (d == 1) begin
            if1.req_a = a; if1.req_b = b; if1.req_sel = sel; if1.req_tag = tag; if1.req_valid = 1'b1;
        end else begin
            if3.req_a = a; if3.req_b = b; if3.req_sel = sel; if3.req_tag = tag; if3.req_valid = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!rdy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(d)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout dut%0d tag %0d: req_ready 0, want 1", d, tag);
            if (d == 1) if1.req_valid = 1'b0; else if3.req_valid = 1'b0;
            return;
        end
        x.e.result = er;
        x.e.cout   = ec;
        x.e.sel    = sel;
        x.e.tag    = tag;
        x.fire     = cyc + 1;
        x.lat      = lat;
        if (push) begin
            if (d == 1) q1.push_back(x); else q3.push_back(x);
        end
        @(posedge clk);
        #1;
        if (d == 1) if1.req_valid = 1'b0; else if3.req_valid = 1'b0;
    endtask

    // Monitor for the ALU_LAT=1 instance
    always @(negedge clk) begin
        if (rst_n && if1.rsp_valid && if1.rsp_ready) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp1_unexpected: got tag %0d, want no response", if1.rsp_tag);
            end else begin
                x1 = q1.pop_front();
                chk("rsp1_entry", 64'({if1.rsp_result, if1.rsp_cout, if1.rsp_sel, if1.rsp_tag}), 64'(x1.e));
                if (x1.lat) chk("rsp1_latency", 64'(cyc - x1.fire), 64'd2);
            end
        end
    end

    // Monitor for the ALU_LAT=3 instance
    always @(negedge clk) begin
        if (rst_n && if3.rsp_valid && if3.rsp_ready) begin
            if (q3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp3_unexpected: got tag %0d, want no response", if3.rsp_tag);
            end else begin
                x3 = q3.pop_front();
                chk("rsp3_entry", 64'({if3.rsp_result, if3.rsp_cout, if3.rsp_sel, if3.rsp_tag}), 64'(x3.e));
                if (x3.lat) chk("rsp3_latency", 64'(cyc - x3.fire), 64'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, er;
        logic        ec;
        int          n;

        rst_n = 1'b0;
        if1.req_valid = 1'b0; if1.req_a = '0; if1.req_b = '0; if1.req_sel = 1'b0; if1.req_tag = '0;
        if3.req_valid = 1'b0; if3.req_a = '0; if3.req_b = '0; if3.req_sel = 1'b0; if3.req_tag = '0;
        if1.rsp_ready = 1'b1;
        if3.rsp_ready = 1'b1;

        // Reset state and release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(if1.req_ready), 64'd0);
        chk("rst_alu_a", 64'(a1), 64'd0);
        chk("rst_rsp_valid", 64'(if1.rsp_valid), 64'd0);
        chk("rst_ops_done", 64'(ops1), 64'd0);
        chk("rst_rsp_result", 64'(if1.rsp_result), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", 64'(if1.req_ready), 64'd0);
        @(negedge clk);
        chk("rdy_after_release", 64'(if1.req_ready), 64'd1);

        // Add, carry, NOT with the consumer always ready
        send(1, 32'h0000_0000, 32'h1111_1111, 1'b0, 4'd3, 32'h1111_1111, 1'b0, 1'b1, 1'b1);
        send(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        send(1, 32'h0000_0000, 32'h1111_1111, 1'b1, 4'd7, 32'hEEEE_EEEE, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        chk("ops_done_3", 64'(ops1), 64'd3);
        chk("drain1", 64'(q1.size()), 64'd0);

        // Reset while WAIT: outputs clear at once, killed op never returns
        send(1, 32'h1234_5678, 32'h0000_0001, 1'b0, 4'd9, 32'h1234_5679, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", 64'(a1), 64'd0);
        chk("midrst_alu_b", 64'(b1), 64'd0);
        chk("midrst_req_ready", 64'(if1.req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(if1.rsp_valid), 64'd0);
        chk("midrst_ops_done", 64'(ops1), 64'd0);
        chk("midrst_rsp_result", 64'(if1.rsp_result), 64'd0);
        chk("midrst_rsp_tag", 64'(if1.rsp_tag), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready_after", 64'(if1.req_ready), 64'd1);
        repeat (8) @(negedge clk);
        chk("midrst_no_capture", 64'(ops1), 64'd0);

        // Backpressure: two stored, third held off until one pop
        @(posedge clk);
        #1 if1.rsp_ready = 1'b0;
        send(1, 32'h10, 32'h1, 1'b0, 4'd1, 32'h11, 1'b0, 1'b1, 1'b0);
        send(1, 32'h20, 32'h2, 1'b0, 4'd2, 32'h22, 1'b0, 1'b1, 1'b0);
        fork
            begin
                send(1, 32'h30, 32'h3, 1'b0, 4'd3, 32'h33, 1'b0, 1'b1, 1'b0);
                bg_done = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        chk("full_req_ready", 64'(if1.req_ready), 64'd0);
        chk("full_rsp_valid", 64'(if1.rsp_valid), 64'd1);
        chk("full_head_tag", 64'(if1.rsp_tag), 64'd1);
        chk("full_head_result", 64'(if1.rsp_result), 64'h11);
        @(posedge clk);
        #1 if1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 if1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("slot_freed", 64'(if1.req_ready), 64'd1);
        n = 0;
        while (!bg_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tag3_accepted", 64'(bg_done), 64'd1);
        @(posedge clk);
        #1 if1.rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("drain_bp", 64'(q1.size()), 64'd0);
        chk("ops_done_bp", 64'(ops1), 64'd3);

        // ALU_LAT=3: ten ops with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            a = 32'hFFFF_FFF8 + 32'(i);
            {ec, er} = {1'b0, a} + 33'h4;
            send(3, a, 32'h4, 1'b0, 4'(i), er, ec, 1'b1, 1'b1);
        end
        repeat (8) @(negedge clk);
        chk("ops_done_10", 64'(ops3), 64'd10);
        chk("drain3", 64'(q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator-side front end for the registered 32-bit add/NOT ALU.
- Accepts operation requests (A, B, select, tag) on a valid/ready interface and drives the ALU operand and select inputs.
- Waits the ALU's fixed clocked latency, captures result and carry-out, and returns them on a valid/ready response interface through a small response FIFO.
- Replaces hand-driven operand stimulus; sits between the datapath sequencer and the ALU.

Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 4, request tag width, echoed on the response
- ALU_LAT, 1, ALU clocked latency in cycles (edges from operand change to result valid); legal range 1..7
- RSP_DEPTH, 2, response FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B
- req_sel  in  1  ALU select (0 = add, 1 = NOT op)
- req_tag  in  TAG_W  request identifier
- alu_a  out  DATA_W  registered operand A to ALU
- alu_b  out  DATA_W  registered operand B to ALU
- alu_sel  out  1  registered select to ALU
- alu_result  in  DATA_W  ALU result
- alu_cout  in  1  ALU carry-out
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  head result
- rsp_cout  out  1  head carry-out
- rsp_sel  out  1  head select echo
- rsp_tag  out  TAG_W  head tag echo
- ops_done  out  16  saturating count of completed captures

Behaviour:
- Interface decision (already decided): one clock, clk; reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0 and release on the next clk rising edge after rst_n=1.
- Reset values:
  - req_ready=0 while rst_n=0; 1 in the first cycle after release.
  - alu_a, alu_b, alu_sel = 0.
  - rsp_valid=0; rsp_result, rsp_cout, rsp_sel, rsp_tag = 0; ops_done=0.
  - FIFO empty; FSM in IDLE.
- FSM states: IDLE, WAIT, CAPT.
  - IDLE: req_ready = (fifo_count < RSP_DEPTH). On fire (req_valid & req_ready), at edge E0:
    - load alu_a/alu_b/alu_sel from the request;
    - latch req_tag internally;
    - load wait counter = ALU_LAT;
    - go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each edge; go to CAPT on the edge where the counter reaches 0 (edge E0+ALU_LAT).
  - CAPT: req_ready=0. At edge E0+ALU_LAT+1, push {alu_result, alu_cout, alu_sel, tag} into the FIFO; ops_done++ (saturates at 0xFFFF); return to IDLE.
- Timing:
  - Request-to-rsp_valid latency = ALU_LAT+1 cycles (2 at default).
  - Throughput: one op per ALU_LAT+2 cycles.
  - alu_* hold their values until the next fire.
- Only one operation is outstanding at a time. FIFO space is guaranteed at push because the space check is made at issue.
- req_ready has no combinational path from rsp_ready or from the same-cycle pop. A pop frees a slot visible one cycle later.
- Response FIFO:
  - rsp_* present the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_* hold stable while rsp_valid & !rsp_ready.
- Full: with RSP_DEPTH entries stored, req_ready=0 indefinitely until a pop.
- Empty: rsp_valid=0; rsp_* hold the last popped values (no X).
- rst_n asserted mid-operation: the in-flight op is discarded, FIFO contents are lost, and the ALU result is not captured.
- req_* values are ignored when not firing. req_valid may drop without a handshake.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, WAIT, CAPT};
  - DATA_W/TAG_W defaults;
  - response entry struct {result, cout, sel, tag}.
- One sub-module: alu_rsp_fifo (parameterised depth/width, count output, async active-low reset).

Test Plan:
- Stub ALU on the bench: registered, latency ALU_LAT; sel=0 → A+B with cout; sel=1 → ~B, cout=0.
- Reset: assert rst_n=0 mid-WAIT → all outputs 0 immediately; after release, req_ready=1 and no response ever appears for the killed op.
- Single add: A=0x00000000, B=0x11111111, sel=0, tag=3 → rsp_valid 2 cycles after fire; result=0x11111111, cout=0, tag=3; ops_done=1.
- Carry: A=0xFFFFFFFF, B=0x00000001, sel=0 → result=0x00000000, cout=1.
- NOT op: A=0x00000000, B=0x11111111, sel=1, tag=7 → result=0xEEEEEEEE, sel=1, tag=7.
- Backpressure: rsp_ready=0, issue 3 requests (tags 1, 2, 3) → tags 1 and 2 stored, req_ready=0 with tag 3 pending. Raise rsp_ready for one cycle → tag 1 popped; tag 3 accepted the following cycle; order 1, 2, 3 preserved.
- Simultaneous push/pop: rsp_ready held 1 over 10 back-to-back ops with ALU_LAT=3 → each response arrives exactly 4 cycles after its fire; ops_done=10.
